// File: rtl/counter_sequencer.sv
// Command sequencer for a 3-bit up/down counter: queues step commands, drives
// count enable/direction for the commanded cycles, reports final value and wraps.
module counter_sequencer #(
  parameter int QDEPTH = 2,
  parameter int WRAPW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [2:0]       cmd_steps,
  input  logic             abort,
  output logic             cnt_en,
  output logic             cnt_inc,
  input  logic [2:0]       cnt_q,
  input  logic             cnt_cout,
  output logic             busy,
  output logic             done,
  output logic [2:0]       final_q,
  output logic [WRAPW-1:0] wrap_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic             q_dir_q [QDEPTH];
  logic             q_dir_d [QDEPTH];
  logic [2:0]       q_steps_q [QDEPTH];
  logic [2:0]       q_steps_d [QDEPTH];
  logic [3:0]       rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             en_q, en_d;
  logic             inc_q, inc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       fin_q, fin_d;
  logic [WRAPW-1:0] wrap_q, wrap_d;
  logic             pend_q, pend_d;
  logic             push, pop, wslot;

  // Readiness uses registered occupancy only, so a full queue refuses even on a pop cycle.
  assign cmd_ready  = (occ_q != 2'(QDEPTH)) & ~abort;
  assign push       = cmd_valid & cmd_ready;
  assign pop        = (state_q == IDLE) & (occ_q != 2'd0) & ~abort;
  assign cnt_en     = en_q;
  assign cnt_inc    = inc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign final_q    = fin_q;
  assign wrap_count = wrap_q;

  always_comb begin
    q_dir_d   = q_dir_q;
    q_steps_d = q_steps_q;
    occ_d     = occ_q;
    // A simultaneous push and pop can only happen at occupancy 1, so it lands in slot 0.
    wslot     = pop ? 1'b0 : occ_q[0];
    if (abort) begin
      occ_d = 2'd0;
    end else begin
      if (pop) begin
        q_dir_d[0]   = q_dir_q[1];
        q_steps_d[0] = q_steps_q[1];
      end
      if (push) begin
        q_dir_d[wslot]   = cmd_dir;
        q_steps_d[wslot] = cmd_steps;
      end
      occ_d = occ_q + 2'(push) - 2'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    en_d    = 1'b0;
    inc_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    fin_d   = fin_q;
    wrap_d  = wrap_q;
    pend_d  = en_q;
    if (pend_q & cnt_cout & (wrap_q != '1)) wrap_d = wrap_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (pop) begin
          rem_d   = (q_steps_q[0] == 3'd0) ? 4'd8 : {1'b0, q_steps_q[0]};
          dir_d   = q_dir_q[0];
          wrap_d  = '0;
          state_d = RUN;
          en_d    = 1'b1;
          inc_d   = q_dir_q[0];
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (rem_q == 4'd1) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_q - 4'd1;
          en_d  = 1'b1;
          inc_d = dir_q;
        end
      end
      DONE: begin
        // The counter has already absorbed the last step by now.
        fin_d   = cnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      en_d    = 1'b0;
      inc_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      fin_d   = fin_q;
      wrap_d  = wrap_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      occ_q   <= 2'd0;
      rem_q   <= 4'd0;
      dir_q   <= 1'b0;
      en_q    <= 1'b0;
      inc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fin_q   <= 3'd0;
      wrap_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      en_q    <= en_d;
      inc_q   <= inc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fin_q   <= fin_d;
      wrap_q  <= wrap_d;
      pend_q  <= pend_d;
    end
  end

  // Queue payload needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    q_dir_q   <= q_dir_d;
    q_steps_q <= q_steps_d;
  end

endmodule
